instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
- Next-generation instruction decoder for the pipelined MIPS core.
- Decodes the D-stage instruction into a 6-bit type code over an extended instruction set.
- Carries each instruction's type, destination register and Tnew down a parametrised chain of registered stages (E, M, W, ...).
- From that chain, generates the D-stage stall request for RAW hazards.

Parameters:
- STAGES, 3, number of registered stages after D (index 0 = E, 1 = M, 2 = W); legal range 2..6.
- TYPE_W, 6, width of the type code.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Instr_D  input  32  instruction currently in D.
- valid_D  input  1  Instr_D holds a real instruction; 0 = D bubble.
- Type_D  output  TYPE_W  combinational type code of Instr_D.
- stall  output  1  combinational; 1 = freeze PC and IF/ID and insert a bubble into E.
- type_pipe  output  STAGES*TYPE_W  registered type per stage; stage s occupies bits [s*TYPE_W +: TYPE_W].
- dst_pipe  output  STAGES*5  registered destination register per stage.
- tnew_pipe  output  STAGES*2  registered remaining Tnew per stage.
- valid_pipe  output  STAGES  registered valid per stage.

Behaviour:
- Type codes:
  - nop/bubble=0, addu=1, subu=2, ori=3, lw=4, sw=5, beq=6, lui=7, j=8, jal=9, jr=10, sll=11, addiu=12, bne=13, slt=14, jalr=15, err=63.
  - R-type requires opcode 000000; funct values: addu 100001, subu 100011, jr 001000, sll 000000, slt 101010, jalr 001001.
  - Opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, addiu 001001, bne 000101.
  - Anything else decodes to err=63. Instr 0x00000000 decodes to sll.
- Destination (combinational, D):
  - rd for addu, subu, slt, sll, jalr.
  - rt for ori, lw, lui, addiu.
  - 31 for jal.
  - 0 otherwise, including err.
- Tnew at E entry:
  - 2 for lw.
  - 1 for addu, subu, ori, lui, addiu, slt, sll.
  - 0 otherwise.
- Tuse (D), rs:
  - 0 for beq, bne, jr, jalr.
  - 1 for addu, subu, ori, lw, sw, addiu, slt.
  - 3 (never stalls) otherwise.
- Tuse (D), rt:
  - 0 for beq, bne.
  - 1 for addu, subu, slt, sll.
  - 2 for sw.
  - 3 otherwise.
- Stall (combinational):
  - Asserted iff valid_D and some stage s has valid=1, dst!=0, and one of:
    - dst==Instr_D[25:21] and tnew_s > Tuse_rs;
    - dst==Instr_D[20:16] and tnew_s > Tuse_rt.
  - A match in any stage suffices; no priority is needed.
- Stage 0 (E) update each cycle:
  - If reset: cleared.
  - Else if stall or !valid_D: loaded with a bubble (type 0, dst 0, tnew 0, valid 0).
  - Else: loaded with the decoded D fields (valid 1).
- Stage s>0 update each cycle:
  - If reset: cleared.
  - Else: loads stage s-1, with tnew = max(tnew_{s-1} - 1, 0) (saturating, never wraps).
  - Stages s>0 always advance, including during stall.
- Reset values: all type/dst/tnew/valid outputs 0; stall 0 in the cycle after reset, because pipe registers are cleared.
- Latency: a D instruction appears in E one cycle after an unstalled edge, and in stage s after s+1 edges.
- Multi-cycle stalls:
  - lw in E followed by a D-stage user with Tuse 0 stalls 2 cycles.
  - With Tuse 1, it stalls 1 cycle.
  - Stall self-clears as tnew decays.
- Reset mid-stall: pipe cleared on that edge; stall deasserts the following cycle regardless of Instr_D.
- err instructions propagate normally (dst 0, never cause stalls); exception handling is outside this block.

Test Plan:
- Hold reset high 2 cycles with Instr_D=0x8C030000, valid_D=1 -> all pipe outputs 0 and stall 0 in the cycle after reset; release -> E shows type 4, dst 3, tnew 2.
- addu $3,$1,$2 (0x00221821), then addu $4,$3,$3 (0x00632021) -> no stall; E type 1, dst 3, tnew 1; next cycle M tnew 0, E dst 4.
- lw $3,0($0) (0x8C030000), then addu $4,$3,$1 (0x00612021) -> stall=1 for exactly one cycle; E bubble (type 0, valid 0) while M holds lw with tnew 1; addu enters E next cycle.
- lw $3,0($0), then beq $3,$0 (0x10600000) -> stall 2 cycles; in W lw tnew reads 0; beq decodes as type 6.
- addu $0,$1,$2 (0x00220021), then beq $0,$0 -> no stall (dst 0 exempt); valid_D=0 -> E bubble; 0x7C000000 -> Type_D 63, passes down the pipe with dst 0.
- Force the lw→beq stall, then assert reset in the first stall cycle -> all stages 0 after the edge; stall 0 the next cycle.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// D-stage instruction decoder with a parametrised E/M/W... pipeline of
// type, destination and Tnew, plus the RAW-hazard stall request for D.
module instr_decode_pipe #(
    parameter int STAGES = 3,
    parameter int TYPE_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Instr_D,
    input  logic                     valid_D,
    output logic [TYPE_W-1:0]        Type_D,
    output logic                     stall,
    output logic [STAGES*TYPE_W-1:0] type_pipe,
    output logic [STAGES*5-1:0]      dst_pipe,
    output logic [STAGES*2-1:0]      tnew_pipe,
    output logic [STAGES-1:0]        valid_pipe
);

    typedef enum logic [5:0] {
        IT_NOP   = 6'd0,  IT_ADDU  = 6'd1,  IT_SUBU = 6'd2,  IT_ORI  = 6'd3,
        IT_LW    = 6'd4,  IT_SW    = 6'd5,  IT_BEQ  = 6'd6,  IT_LUI  = 6'd7,
        IT_J     = 6'd8,  IT_JAL   = 6'd9,  IT_JR   = 6'd10, IT_SLL  = 6'd11,
        IT_ADDIU = 6'd12, IT_BNE   = 6'd13, IT_SLT  = 6'd14, IT_JALR = 6'd15,
        IT_ERR   = 6'd63
    } itype_e;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign opcode       = Instr_D[31:26];
    assign rs           = Instr_D[25:21];
    assign rt           = Instr_D[20:16];
    assign rd           = Instr_D[15:11];
    assign funct        = Instr_D[5:0];
    assign unused_shamt = ^Instr_D[10:6];

    itype_e     itype;
    logic [4:0] dst_d;
    logic [1:0] tnew_d, tuse_rs, tuse_rt;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        itype = IT_ERR;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: itype = IT_ADDU;
                    6'b100011: itype = IT_SUBU;
                    6'b001000: itype = IT_JR;
                    6'b000000: itype = IT_SLL;
                    6'b101010: itype = IT_SLT;
                    6'b001001: itype = IT_JALR;
                    default:   itype = IT_ERR;
                endcase
            end
            6'b001101: itype = IT_ORI;
            6'b100011: itype = IT_LW;
            6'b101011: itype = IT_SW;
            6'b000100: itype = IT_BEQ;
            6'b001111: itype = IT_LUI;
            6'b000010: itype = IT_J;
            6'b000011: itype = IT_JAL;
            6'b001001: itype = IT_ADDIU;
            6'b000101: itype = IT_BNE;
            default:   itype = IT_ERR;
        endcase
    end

    // Tuse of 3 can never be exceeded by a 2-bit Tnew, so it means "no stall".
    always_comb begin
        dst_d   = 5'd0;
        tnew_d  = 2'd0;
        tuse_rs = 2'd3;
        tuse_rt = 2'd3;
        case (itype)
            IT_ADDU, IT_SUBU, IT_SLT: begin
                dst_d = rd; tnew_d = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1;
            end
            IT_SLL:   begin dst_d = rd; tnew_d = 2'd1; tuse_rt = 2'd1; end
            IT_JALR:  begin dst_d = rd; tuse_rs = 2'd0; end
            IT_JR:    tuse_rs = 2'd0;
            IT_ORI, IT_ADDIU: begin dst_d = rt; tnew_d = 2'd1; tuse_rs = 2'd1; end
            IT_LW:    begin dst_d = rt; tnew_d = 2'd2; tuse_rs = 2'd1; end
            IT_LUI:   begin dst_d = rt; tnew_d = 2'd1; end
            IT_SW:    begin tuse_rs = 2'd1; tuse_rt = 2'd2; end
            IT_BEQ, IT_BNE: begin tuse_rs = 2'd0; tuse_rt = 2'd0; end
            IT_JAL:   dst_d = 5'd31;
            default:  dst_d = 5'd0;
        endcase
    end

    assign Type_D = TYPE_W'(itype);

    logic [TYPE_W-1:0] type_q [STAGES];
    logic [4:0]        dst_q  [STAGES];
    logic [1:0]        tnew_q [STAGES];
    logic [STAGES-1:0] valid_q;

    // Any in-flight producer whose result is not ready by the consumer's use point stalls D.
    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            if (valid_q[s] && dst_q[s] != 5'd0 &&
                ((dst_q[s] == rs && tnew_q[s] > tuse_rs) ||
                 (dst_q[s] == rt && tnew_q[s] > tuse_rt)))
                stall = 1'b1;
        end
        stall = stall & valid_D;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage reads its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                type_q[s] <= '0;
                dst_q[s]  <= '0;
                tnew_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (stall || !valid_D) begin
                type_q[0]  <= '0;
                dst_q[0]   <= '0;
                tnew_q[0]  <= '0;
                valid_q[0] <= 1'b0;
            end else begin
                type_q[0]  <= Type_D;
                dst_q[0]   <= dst_d;
                tnew_q[0]  <= tnew_d;
                valid_q[0] <= 1'b1;
            end
            for (int s = 1; s < STAGES; s++) begin
                type_q[s]  <= type_q[s-1];
                dst_q[s]   <= dst_q[s-1];
                tnew_q[s]  <= (tnew_q[s-1] == 2'd0) ? 2'd0 : tnew_q[s-1] - 2'd1;
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    always_comb begin
        type_pipe = '0;
        dst_pipe  = '0;
        tnew_pipe = '0;
        for (int s = 0; s < STAGES; s++) begin
            type_pipe[s*TYPE_W +: TYPE_W] = type_q[s];
            dst_pipe[s*5 +: 5]            = dst_q[s];
            tnew_pipe[s*2 +: 2]           = tnew_q[s];
        end
    end

    assign valid_pipe = valid_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Bench for instr_decode_pipe: directed hazard scenarios plus randomized
// traffic, all checked against a table-driven ISA and pipeline model.
module tb_instr_decode_pipe;

    localparam int STAGES = 3;
    localparam int TYPE_W = 6;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [31:0]              Instr_D;
    logic                     valid_D;
    logic [TYPE_W-1:0]        Type_D;
    logic                     stall;
    logic [STAGES*TYPE_W-1:0] type_pipe;
    logic [STAGES*5-1:0]      dst_pipe;
    logic [STAGES*2-1:0]      tnew_pipe;
    logic [STAGES-1:0]        valid_pipe;

    instr_decode_pipe #(.STAGES(STAGES), .TYPE_W(TYPE_W)) dut (
        .clk(clk), .reset(reset), .Instr_D(Instr_D), .valid_D(valid_D),
        .Type_D(Type_D), .stall(stall), .type_pipe(type_pipe),
        .dst_pipe(dst_pipe), .tnew_pipe(tnew_pipe), .valid_pipe(valid_pipe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // dk: 0 = no destination, 1 = rd, 2 = rt, 3 = $31; fn < 0 means I/J-type.
    typedef struct {int op; int fn; int typ; int dk; int tnew; int trs; int trt;} isa_t;
    typedef struct {int typ; int dst; int tnew; int trs; int trt;} dec_t;

    isa_t isa[15];

    function automatic isa_t mk(int op, int fn, int typ, int dk, int tnew, int trs, int trt);
        isa_t e;
        e.op = op; e.fn = fn; e.typ = typ; e.dk = dk; e.tnew = tnew; e.trs = trs; e.trt = trt;
        return e;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        d.typ = 63; d.dst = 0; d.tnew = 0; d.trs = 3; d.trt = 3;
        for (int i = 0; i < 15; i++) begin
            if (isa[i].op == int'(ins[31:26]) && (isa[i].fn < 0 || isa[i].fn == int'(ins[5:0]))) begin
                d.typ = isa[i].typ; d.tnew = isa[i].tnew; d.trs = isa[i].trs; d.trt = isa[i].trt;
                case (isa[i].dk)
                    1: d.dst = int'(ins[15:11]);
                    2: d.dst = int'(ins[20:16]);
                    3: d.dst = 31;
                    default: d.dst = 0;
                endcase
            end
        end
        return d;
    endfunction

    // Pipeline model: one record per stage after D.
    int m_typ [STAGES];
    int m_dst [STAGES];
    int m_tn  [STAGES];
    bit m_v   [STAGES];

    function automatic bit model_stall(input logic [31:0] ins, input bit v);
        dec_t d = ref_decode(ins);
        bit   hz = 1'b0;
        for (int s = 0; s < STAGES; s++)
            if (m_v[s] && m_dst[s] != 0 &&
                ((m_dst[s] == int'(ins[25:21]) && m_tn[s] > d.trs) ||
                 (m_dst[s] == int'(ins[20:16]) && m_tn[s] > d.trt)))
                hz = 1'b1;
        return v && hz;
    endfunction

    task automatic drive(input logic [31:0] ins, input bit v, input bit r);
        dec_t d;
        Instr_D = ins; valid_D = v; reset = r;
        #1;
        d = ref_decode(ins);
        check("type_d", 32'(Type_D), 32'(d.typ));
        check("stall", 32'(stall), 32'(model_stall(ins, v)));
    endtask

    task automatic tick();
        bit   st;
        dec_t d;
        logic [STAGES*TYPE_W-1:0] e_type;
        logic [STAGES*5-1:0]      e_dst;
        logic [STAGES*2-1:0]      e_tn;
        logic [STAGES-1:0]        e_v;
        @(posedge clk);
        st = model_stall(Instr_D, valid_D);
        d  = ref_decode(Instr_D);
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (reset) begin
                m_typ[s] = 0; m_dst[s] = 0; m_tn[s] = 0; m_v[s] = 1'b0;
            end else if (s > 0) begin
                m_typ[s] = m_typ[s-1]; m_dst[s] = m_dst[s-1]; m_v[s] = m_v[s-1];
                m_tn[s]  = (m_tn[s-1] > 0) ? m_tn[s-1] - 1 : 0;
            end else if (st || !valid_D) begin
                m_typ[0] = 0; m_dst[0] = 0; m_tn[0] = 0; m_v[0] = 1'b0;
            end else begin
                m_typ[0] = d.typ; m_dst[0] = d.dst; m_tn[0] = d.tnew; m_v[0] = 1'b1;
            end
        end
        #1;
        for (int s = 0; s < STAGES; s++) begin
            e_type[s*TYPE_W +: TYPE_W] = TYPE_W'(m_typ[s]);
            e_dst[s*5 +: 5]            = 5'(m_dst[s]);
            e_tn[s*2 +: 2]             = 2'(m_tn[s]);
            e_v[s]                     = m_v[s];
        end
        check("type_pipe", 32'(type_pipe), 32'(e_type));
        check("dst_pipe", 32'(dst_pipe), 32'(e_dst));
        check("tnew_pipe", 32'(tnew_pipe), 32'(e_tn));
        check("valid_pipe", 32'(valid_pipe), 32'(e_v));
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            drive(32'h0, 1'b0, 1'b0);
            tick();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          i;
        if ($urandom_range(0, 99) < 5) return $urandom;
        i = $urandom_range(0, 14);
        ins        = $urandom;
        ins[31:26] = 6'(isa[i].op);
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        if (isa[i].fn >= 0) begin
            ins[15:11] = 5'($urandom_range(0, 3));
            ins[5:0]   = 6'(isa[i].fn);
        end
        return ins;
    endfunction

    localparam logic [31:0] LW3   = 32'h8C030000;
    localparam logic [31:0] BEQ30 = 32'h10600000;

    initial begin
        isa[0]  = mk(0, 33, 1, 1, 1, 1, 1);   // addu
        isa[1]  = mk(0, 35, 2, 1, 1, 1, 1);   // subu
        isa[2]  = mk(0, 8, 10, 0, 0, 0, 3);   // jr
        isa[3]  = mk(0, 0, 11, 1, 1, 3, 1);   // sll
        isa[4]  = mk(0, 42, 14, 1, 1, 1, 1);  // slt
        isa[5]  = mk(0, 9, 15, 1, 0, 0, 3);   // jalr
        isa[6]  = mk(13, -1, 3, 2, 1, 1, 3);  // ori
        isa[7]  = mk(35, -1, 4, 2, 2, 1, 3);  // lw
        isa[8]  = mk(43, -1, 5, 0, 0, 1, 2);  // sw
        isa[9]  = mk(4, -1, 6, 0, 0, 0, 0);   // beq
        isa[10] = mk(15, -1, 7, 2, 1, 3, 3);  // lui
        isa[11] = mk(2, -1, 8, 0, 0, 3, 3);   // j
        isa[12] = mk(3, -1, 9, 3, 0, 3, 3);   // jal
        isa[13] = mk(9, -1, 12, 2, 1, 1, 3);  // addiu
        isa[14] = mk(5, -1, 13, 0, 0, 0, 0);  // bne
        for (int s = 0; s < STAGES; s++) begin
            m_typ[s] = 0; m_dst[s] = 0; m_tn[s] = 0; m_v[s] = 1'b0;
        end

        // Reset held two cycles with a live lw in D.
        drive(LW3, 1'b1, 1'b1); tick();
        drive(LW3, 1'b1, 1'b1); tick();
        check("rst_valid", 32'(valid_pipe), 32'h0);
        check("rst_type", 32'(type_pipe), 32'h0);
        drive(LW3, 1'b1, 1'b0);
        check("rst_stall", 32'(stall), 32'h0);
        tick();
        check("lw_e_type", 32'(type_pipe[5:0]), 32'd4);
        check("lw_e_dst", 32'(dst_pipe[4:0]), 32'd3);
        check("lw_e_tnew", 32'(tnew_pipe[1:0]), 32'd2);

        // addu -> dependent addu: no stall.
        drive(32'h00221821, 1'b1, 1'b0); tick();
        check("addu_e_type", 32'(type_pipe[5:0]), 32'd1);
        check("addu_e_tnew", 32'(tnew_pipe[1:0]), 32'd1);
        drive(32'h00632021, 1'b1, 1'b0);
        check("addu_nostall", 32'(stall), 32'h0);
        tick();
        check("addu_m_tnew", 32'(tnew_pipe[3:2]), 32'd0);
        check("addu_e_dst", 32'(dst_pipe[4:0]), 32'd4);
        flush(3);

        // lw -> addu user: one stall cycle.
        drive(LW3, 1'b1, 1'b0); tick();
        drive(32'h00612021, 1'b1, 1'b0);
        check("lwuse_stall", 32'(stall), 32'h1);
        tick();
        check("lwuse_e_bubble", 32'(valid_pipe[0]), 32'h0);
        check("lwuse_m_tnew", 32'(tnew_pipe[3:2]), 32'd1);
        drive(32'h00612021, 1'b1, 1'b0);
        check("lwuse_release", 32'(stall), 32'h0);
        tick();
        check("lwuse_e_type", 32'(type_pipe[5:0]), 32'd1);
        flush(3);

        // lw -> beq: two stall cycles.
        drive(LW3, 1'b1, 1'b0); tick();
        drive(BEQ30, 1'b1, 1'b0);
        check("lwbeq_stall1", 32'(stall), 32'h1);
        tick();
        drive(BEQ30, 1'b1, 1'b0);
        check("lwbeq_stall2", 32'(stall), 32'h1);
        tick();
        drive(BEQ30, 1'b1, 1'b0);
        check("lwbeq_release", 32'(stall), 32'h0);
        check("lwbeq_w_tnew", 32'(tnew_pipe[5:4]), 32'd0);
        check("beq_type", 32'(Type_D), 32'd6);
        tick();
        flush(3);

        // $0 destination exempt, D bubble, err decode.
        drive(32'h00220021, 1'b1, 1'b0); tick();
        drive(32'h10000000, 1'b1, 1'b0);
        check("dst0_nostall", 32'(stall), 32'h0);
        tick();
        drive(32'h10000000, 1'b0, 1'b0); tick();
        check("bubble_e_valid", 32'(valid_pipe[0]), 32'h0);
        drive(32'h7C000000, 1'b1, 1'b0);
        check("err_type", 32'(Type_D), 32'd63);
        tick();
        flush(2);
        check("err_w_type", 32'(type_pipe[17:12]), 32'd63);
        check("err_w_dst", 32'(dst_pipe[14:10]), 32'd0);
        flush(1);

        // Reset during the first lw->beq stall cycle.
        drive(LW3, 1'b1, 1'b0); tick();
        drive(BEQ30, 1'b1, 1'b1);
        check("midrst_stall", 32'(stall), 32'h1);
        tick();
        check("midrst_valid", 32'(valid_pipe), 32'h0);
        drive(BEQ30, 1'b1, 1'b0);
        check("midrst_release", 32'(stall), 32'h0);
        tick();

        // Randomized traffic with dense register reuse.
        for (int n = 0; n < 600; n++) begin
            drive(rand_instr(), $urandom_range(0, 99) >= 15, $urandom_range(0, 99) < 2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
